// File: rtl/tlb_cam_if.sv
// CP0 / translation-port bundle between the pipeline (master) and the joint TLB (slave).
interface tlb_cam_if #(
    parameter int TLB_ENTRIES = 16
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);

    logic             tlbwi;
    logic             tlbwr;
    logic [IDX_W-1:0] idx_in;
    logic [31:0]      entryhi_in;
    logic [31:0]      pagemask_in;
    logic [31:0]      entrylo0_in;
    logic [31:0]      entrylo1_in;
    logic             wired_we;
    logic [IDX_W-1:0] wired_in;
    logic [IDX_W-1:0] random_out;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_entryhi;
    logic [31:0]      rd_pagemask;
    logic [31:0]      rd_entrylo0;
    logic [31:0]      rd_entrylo1;
    logic             probe_req;
    logic             probe_done;
    logic [31:0]      probe_index;
    logic [7:0]       asid_in;
    logic             i_req;
    logic             d_req;
    logic [31:0]      i_vaddr;
    logic [31:0]      d_vaddr;
    logic             i_rvalid;
    logic             d_rvalid;
    logic [31:0]      i_paddr;
    logic [31:0]      d_paddr;
    logic             i_miss;
    logic             d_miss;
    logic             i_valid;
    logic             d_valid;
    logic [2:0]       i_cache;
    logic [2:0]       d_cache;
    logic             d_dirty;
    logic             mhit;

    modport master (
        output tlbwi, tlbwr, idx_in, entryhi_in, pagemask_in, entrylo0_in, entrylo1_in,
               wired_we, wired_in, rd_idx, probe_req, asid_in, i_req, d_req, i_vaddr, d_vaddr,
        input  random_out, rd_entryhi, rd_pagemask, rd_entrylo0, rd_entrylo1, probe_done,
               probe_index, i_rvalid, d_rvalid, i_paddr, d_paddr, i_miss, d_miss, i_valid,
               d_valid, i_cache, d_cache, d_dirty, mhit
    );

    modport slave (
        input  tlbwi, tlbwr, idx_in, entryhi_in, pagemask_in, entrylo0_in, entrylo1_in,
               wired_we, wired_in, rd_idx, probe_req, asid_in, i_req, d_req, i_vaddr, d_vaddr,
        output random_out, rd_entryhi, rd_pagemask, rd_entrylo0, rd_entrylo1, probe_done,
               probe_index, i_rvalid, d_rvalid, i_paddr, d_paddr, i_miss, d_miss, i_valid,
               d_valid, i_cache, d_cache, d_dirty, mhit
    );
endinterface

// File: rtl/tlb_cam_unit.sv
// Fully-associative MIPS32 joint TLB: CP0 write/read/probe, Random/Wired, registered IF and MEM lookups.
// Optional multiple-hit detection is enabled by defining TLB_MULTIHIT_EN.
module tlb_cam_unit #(
    parameter int TLB_ENTRIES = 16
) (
    input  logic     clk,
    input  logic     rst,
    tlb_cam_if.slave bus
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);
    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        miss;
        logic        valid;
        logic [2:0]  cache;
    } xlat_t;

    logic [18:0] r_vpn2 [TLB_ENTRIES];
    logic [7:0]  r_asid [TLB_ENTRIES];
    logic [11:0] r_mask [TLB_ENTRIES];
    logic        r_g    [TLB_ENTRIES];
    // Never-written entries must not match, otherwise a zeroed entry hits VPN2 0 / ASID 0.
    logic        r_used [TLB_ENTRIES];
    logic [19:0] r_pfn0 [TLB_ENTRIES];
    logic [19:0] r_pfn1 [TLB_ENTRIES];
    logic [2:0]  r_c0   [TLB_ENTRIES];
    logic [2:0]  r_c1   [TLB_ENTRIES];
    logic        r_d0   [TLB_ENTRIES];
    logic        r_d1   [TLB_ENTRIES];
    logic        r_v0   [TLB_ENTRIES];
    logic        r_v1   [TLB_ENTRIES];

    idx_t        r_random;
    idx_t        r_wired;
    logic        r_i_rvalid;
    logic        r_d_rvalid;
    xlat_t       r_i_res;
    xlat_t       r_d_res;
    logic        r_d_dirty;
    logic        r_probe_done;
    logic [31:0] r_probe_index;

    logic [TLB_ENTRIES-1:0] w_i_hits;
    logic [TLB_ENTRIES-1:0] w_d_hits;
    logic [TLB_ENTRIES-1:0] w_p_hits;
    xlat_t                  w_i_res;
    xlat_t                  w_d_res;
    logic                   w_d_dirty;
    logic                   w_we;
    idx_t                   w_widx;
    logic                   w_unused_bits;

    function automatic idx_t first_hit(input logic [TLB_ENTRIES-1:0] v);
        idx_t k;
        k = '0;
        for (int n = TLB_ENTRIES - 1; n >= 0; n--) begin
            if (v[n]) k = idx_t'(n);
        end
        return k;
    endfunction

    function automatic logic multi_hit(input logic [TLB_ENTRIES-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

    // Mask is contiguous from bit 13, so offset+1 is the one-hot odd/even select bit.
    function automatic logic odd_half(input idx_t k, input logic [31:0] va);
        logic [31:0] off;
        off = {8'b0, r_mask[k], 12'hFFF};
        return |(va & (off + 32'd1));
    endfunction

    function automatic xlat_t xlate(input logic [TLB_ENTRIES-1:0] hits, input logic [31:0] va);
        xlat_t       res;
        idx_t        k;
        logic        odd;
        logic [31:0] off;
        logic [31:0] base;
        k    = first_hit(hits);
        odd  = odd_half(k, va);
        off  = {8'b0, r_mask[k], 12'hFFF};
        base = {odd ? r_pfn1[k] : r_pfn0[k], 12'b0};
        res  = '0;
        res.miss = ~|hits;
        if (|hits) begin
            res.paddr = (base & ~off) | (va & off);
            res.valid = odd ? r_v1[k] : r_v0[k];
            res.cache = odd ? r_c1[k] : r_c0[k];
        end
        return res;
    endfunction

    function automatic logic dirty_of(input logic [TLB_ENTRIES-1:0] hits, input logic [31:0] va);
        idx_t k;
        k = first_hit(hits);
        if (!(|hits)) return 1'b0;
        return odd_half(k, va) ? r_d1[k] : r_d0[k];
    endfunction

    for (genvar e = 0; e < TLB_ENTRIES; e++) begin : g_match
        logic [18:0] w_keep;
        assign w_keep      = ~{7'b0, r_mask[e]};
        assign w_i_hits[e] = r_used[e] && ((r_vpn2[e] & w_keep) == (bus.i_vaddr[31:13] & w_keep))
                             && (r_g[e] || (r_asid[e] == bus.asid_in));
        assign w_d_hits[e] = r_used[e] && ((r_vpn2[e] & w_keep) == (bus.d_vaddr[31:13] & w_keep))
                             && (r_g[e] || (r_asid[e] == bus.asid_in));
        assign w_p_hits[e] = r_used[e] && ((r_vpn2[e] & w_keep) == (bus.entryhi_in[31:13] & w_keep))
                             && (r_g[e] || (r_asid[e] == bus.entryhi_in[7:0]));
    end

    assign w_i_res       = xlate(w_i_hits, bus.i_vaddr);
    assign w_d_res       = xlate(w_d_hits, bus.d_vaddr);
    assign w_d_dirty     = dirty_of(w_d_hits, bus.d_vaddr);
    assign w_we          = bus.tlbwi | bus.tlbwr;
    assign w_widx        = bus.tlbwi ? bus.idx_in : r_random;
    assign w_unused_bits = ^{bus.entryhi_in[12:8], bus.pagemask_in[31:25], bus.pagemask_in[12:0],
                             bus.entrylo0_in[31:26], bus.entrylo1_in[31:26]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < TLB_ENTRIES; e++) begin
                r_vpn2[e] <= '0;
                r_asid[e] <= '0;
                r_mask[e] <= '0;
                r_g[e]    <= 1'b0;
                r_used[e] <= 1'b0;
                r_pfn0[e] <= '0;
                r_pfn1[e] <= '0;
                r_c0[e]   <= '0;
                r_c1[e]   <= '0;
                r_d0[e]   <= 1'b0;
                r_d1[e]   <= 1'b0;
                r_v0[e]   <= 1'b0;
                r_v1[e]   <= 1'b0;
            end
        end else if (w_we) begin
            r_vpn2[w_widx] <= bus.entryhi_in[31:13];
            r_asid[w_widx] <= bus.entryhi_in[7:0];
            r_mask[w_widx] <= bus.pagemask_in[24:13];
            r_g[w_widx]    <= bus.entrylo0_in[0] & bus.entrylo1_in[0];
            r_used[w_widx] <= 1'b1;
            r_pfn0[w_widx] <= bus.entrylo0_in[25:6];
            r_pfn1[w_widx] <= bus.entrylo1_in[25:6];
            r_c0[w_widx]   <= bus.entrylo0_in[5:3];
            r_c1[w_widx]   <= bus.entrylo1_in[5:3];
            r_d0[w_widx]   <= bus.entrylo0_in[2];
            r_d1[w_widx]   <= bus.entrylo1_in[2];
            r_v0[w_widx]   <= bus.entrylo0_in[1];
            r_v1[w_widx]   <= bus.entrylo1_in[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_random <= idx_t'(TLB_ENTRIES - 1);
            r_wired  <= '0;
        end else if (bus.wired_we) begin
            r_wired  <= bus.wired_in;
            r_random <= idx_t'(TLB_ENTRIES - 1);
        end else if (r_random <= r_wired) begin
            r_random <= idx_t'(TLB_ENTRIES - 1);
        end else begin
            r_random <= r_random - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_rvalid    <= 1'b0;
            r_d_rvalid    <= 1'b0;
            r_i_res       <= '0;
            r_d_res       <= '0;
            r_d_dirty     <= 1'b0;
            r_probe_done  <= 1'b0;
            r_probe_index <= '0;
        end else begin
            r_i_rvalid   <= bus.i_req;
            r_d_rvalid   <= bus.d_req;
            r_probe_done <= bus.probe_req;
            if (bus.i_req) r_i_res <= w_i_res;
            if (bus.d_req) begin
                r_d_res   <= w_d_res;
                r_d_dirty <= w_d_dirty;
            end
            if (bus.probe_req) begin
                r_probe_index <= (|w_p_hits) ? {{(32-IDX_W){1'b0}}, first_hit(w_p_hits)}
                                             : 32'h8000_0000;
            end
        end
    end

`ifdef TLB_MULTIHIT_EN
    logic r_mhit;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mhit <= 1'b0;
        end else if ((bus.i_req && multi_hit(w_i_hits)) || (bus.d_req && multi_hit(w_d_hits))
                     || (bus.probe_req && multi_hit(w_p_hits))) begin
            r_mhit <= 1'b1;
        end
    end
    assign bus.mhit = r_mhit;
`else
    assign bus.mhit = 1'b0;
`endif

    assign bus.random_out  = r_random;
    assign bus.rd_entryhi  = {r_vpn2[bus.rd_idx], 5'b0, r_asid[bus.rd_idx]};
    assign bus.rd_pagemask = {7'b0, r_mask[bus.rd_idx], 13'b0};
    assign bus.rd_entrylo0 = {6'b0, r_pfn0[bus.rd_idx], r_c0[bus.rd_idx], r_d0[bus.rd_idx],
                              r_v0[bus.rd_idx], r_g[bus.rd_idx]};
    assign bus.rd_entrylo1 = {6'b0, r_pfn1[bus.rd_idx], r_c1[bus.rd_idx], r_d1[bus.rd_idx],
                              r_v1[bus.rd_idx], r_g[bus.rd_idx]};
    assign bus.probe_done  = r_probe_done;
    assign bus.probe_index = r_probe_index;
    assign bus.i_rvalid    = r_i_rvalid;
    assign bus.d_rvalid    = r_d_rvalid;
    assign bus.i_paddr     = r_i_res.paddr;
    assign bus.d_paddr     = r_d_res.paddr;
    assign bus.i_miss      = r_i_res.miss;
    assign bus.d_miss      = r_d_res.miss;
    assign bus.i_valid     = r_i_res.valid;
    assign bus.d_valid     = r_d_res.valid;
    assign bus.i_cache     = r_i_res.cache;
    assign bus.d_cache     = r_d_res.cache;
    assign bus.d_dirty     = r_d_dirty;
endmodule
